// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl: program-counter sequencing controller.
// Drives load/increment strobes of an external counter, issues fetch requests,
// and handles redirects, halt/resume and an optional wrap trap.
// Optional feature macro: PC_SEQ_WRAP_TRAP_EN. When it is defined, an accepted
// fetch at the all-ones address sets a sticky wrap_err and enters HALT.

module pc_seq_ctrl #(
    parameter int unsigned          WIDTH        = 5,
    parameter logic [WIDTH-1:0]     RESET_VECTOR = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] cnt_out,
    output logic             cnt_load,
    output logic             cnt_enable,
    output logic [WIDTH-1:0] cnt_in,
    output logic             fetch_valid,
    input  logic             fetch_ready,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic             halted,
    output logic             wrap_err
);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e           state_q;
    state_e           state_d;
    logic             halted_q;
    logic             trap_c;
    logic             load_c;
    logic             enable_c;
    logic [WIDTH-1:0] in_c;
    logic             fetch_c;

    // Next-state and combinational strobe decode
    always_comb begin
        state_d  = state_q;
        load_c   = 1'b0;
        enable_c = 1'b0;
        in_c     = '0;
        fetch_c  = 1'b0;
        trap_c   = 1'b0;
        case (state_q)
            ST_INIT: begin
                load_c  = 1'b1;
                in_c    = RESET_VECTOR;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redir_valid) begin
                    // Redirect squashes this cycle's fetch, leaving a 1-cycle bubble
                    load_c = 1'b1;
                    in_c   = redir_target;
                end else begin
                    fetch_c  = 1'b1;
                    enable_c = fetch_ready;
`ifdef PC_SEQ_WRAP_TRAP_EN
                    if (fetch_ready && (cnt_out == {WIDTH{1'b1}})) begin
                        enable_c = 1'b0;
                        trap_c   = 1'b1;
                    end
`endif
                end
                if (halt_req || trap_c) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (redir_valid) begin
                    load_c = 1'b1;
                    in_c   = redir_target;
                end
                if (resume && !halt_req) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // Strobes are forced quiet while reset is held
    always_comb begin
        cnt_load    = rst & load_c;
        cnt_enable  = rst & enable_c;
        cnt_in      = rst ? in_c : '0;
        fetch_valid = rst & fetch_c;
    end

    // State and halted flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_INIT;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == ST_HALT);
        end
    end

    assign halted = halted_q;

`ifdef PC_SEQ_WRAP_TRAP_EN
    logic wrap_err_q;

    // Sticky wrap trap flag, cleared only by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrap_err_q <= 1'b0;
        end else begin
            wrap_err_q <= wrap_err_q | trap_c;
        end
    end

    assign wrap_err = wrap_err_q;
`else
    // Counter value only matters to the wrap trap; silent wrap needs nothing
    logic unused_cnt_out;
    assign unused_cnt_out = ^cnt_out;
    assign wrap_err       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed bench for pc_seq_ctrl with a behavioural counter model and a
// fetch-address scoreboard. Build with +define+PC_SEQ_WRAP_TRAP_EN for trap mode.

module tb_pc_seq_ctrl;

    localparam int unsigned W = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] cnt = '0;
    logic         cnt_load;
    logic         cnt_enable;
    logic [W-1:0] cnt_in;
    logic         fetch_valid;
    logic         fetch_ready = 1'b0;
    logic         redir_valid = 1'b0;
    logic [W-1:0] redir_target = '0;
    logic         halt_req = 1'b0;
    logic         resume = 1'b0;
    logic         halted;
    logic         wrap_err;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_q[$];

    pc_seq_ctrl #(.WIDTH(W), .RESET_VECTOR(5'h05)) dut (
        .clk         (clk),
        .rst         (rst),
        .cnt_out     (cnt),
        .cnt_load    (cnt_load),
        .cnt_enable  (cnt_enable),
        .cnt_in      (cnt_in),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted),
        .wrap_err    (wrap_err)
    );

    always #5 clk = ~clk;

    // Controlled counter model: load beats increment, increment wraps mod 2^W
    always @(posedge clk) begin
        if (cnt_load)        cnt <= cnt_in;
        else if (cnt_enable) cnt <= cnt + 5'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard: every accepted fetch must match the next expected address
    always @(negedge clk) begin
        if (rst && fetch_valid && fetch_ready) begin
            chk("fetch_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) chk("fetch_addr", 32'(cnt), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset asserted: quiet outputs
        #1 rst = 1'b0;
        #1;
        chk("rst_load",   32'(cnt_load),    32'd0);
        chk("rst_fv",     32'(fetch_valid), 32'd0);
        chk("rst_halted", 32'(halted),      32'd0);
        chk("rst_wrap",   32'(wrap_err),    32'd0);
        tick(); tick();
        // Release: INIT loads reset vector
        rst = 1'b1; fetch_ready = 1'b1;
        #1;
        chk("init_load", 32'(cnt_load),    32'd1);
        chk("init_in",   32'(cnt_in),      32'h05);
        chk("init_fv",   32'(fetch_valid), 32'd0);
        exp_q.push_back(5'h05); exp_q.push_back(5'h06); exp_q.push_back(5'h07);
        tick(); #1;
        chk("run_fv",   32'(fetch_valid), 32'd1);
        chk("run_en",   32'(cnt_enable),  32'd1);
        chk("run_in0",  32'(cnt_in),      32'd0);
        tick(); tick(); #1;
        chk("run_addr7", 32'(cnt), 32'h07);
        // Redirect with fetch_ready high squashes the fetch
        tick();
        redir_valid = 1'b1; redir_target = 5'h0A;
        #1;
        chk("redir_fv",   32'(fetch_valid), 32'd0);
        chk("redir_en",   32'(cnt_enable),  32'd0);
        chk("redir_load", 32'(cnt_load),    32'd1);
        chk("redir_in",   32'(cnt_in),      32'h0A);
        // Backpressure for three cycles
        tick();
        redir_valid = 1'b0; fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            #1;
            chk("stall_fv",   32'(fetch_valid), 32'd1);
            chk("stall_en",   32'(cnt_enable),  32'd0);
            chk("stall_addr", 32'(cnt),         32'h0A);
        end
        tick();
        fetch_ready = 1'b1; exp_q.push_back(5'h0A);
        #1;
        chk("unstall_en", 32'(cnt_enable), 32'd1);
        tick();
        exp_q.push_back(5'h0B);
        #1;
        chk("addr_0b", 32'(cnt), 32'h0B);
        // Redirect and halt together
        tick();
        halt_req = 1'b1; redir_valid = 1'b1; redir_target = 5'h1F;
        #1;
        chk("rh_fv",   32'(fetch_valid), 32'd0);
        chk("rh_load", 32'(cnt_load),    32'd1);
        chk("rh_in",   32'(cnt_in),      32'h1F);
        chk("rh_en",   32'(cnt_enable),  32'd0);
        tick();
        redir_valid = 1'b0;
        #1;
        chk("halt_halted", 32'(halted),      32'd1);
        chk("halt_fv",     32'(fetch_valid), 32'd0);
        chk("halt_en",     32'(cnt_enable),  32'd0);
        chk("halt_load",   32'(cnt_load),    32'd0);
        tick();
        resume = 1'b1;
        #1;
        chk("halt_hold",  32'(cnt),    32'h1F);
        chk("halt_still", 32'(halted), 32'd1);
        tick();
        halt_req = 1'b0; exp_q.push_back(5'h1F);
        #1;
        chk("ignored_resume", 32'(halted),      32'd1);
        chk("resume_fv",      32'(fetch_valid), 32'd0);
        tick();
        resume = 1'b0;
        #1;
        chk("resumed_halted", 32'(halted),      32'd0);
        chk("resumed_fv",     32'(fetch_valid), 32'd1);
        chk("resumed_addr",   32'(cnt),         32'h1F);
`ifdef PC_SEQ_WRAP_TRAP_EN
        chk("trap_en", 32'(cnt_enable), 32'd0);
        tick();
        resume = 1'b1;
        #1;
        chk("trap_wrap",   32'(wrap_err),    32'd1);
        chk("trap_halted", 32'(halted),      32'd1);
        chk("trap_addr",   32'(cnt),         32'h1F);
        chk("trap_fv",     32'(fetch_valid), 32'd0);
        tick();
        resume = 1'b0; fetch_ready = 1'b0;
        #1;
        chk("trap_resumed", 32'(halted),      32'd0);
        chk("trap_sticky",  32'(wrap_err),    32'd1);
        chk("trap_run_fv",  32'(fetch_valid), 32'd1);
`else
        chk("wrap_en",   32'(cnt_enable), 32'd1);
        chk("wrap_flag", 32'(wrap_err),   32'd0);
        tick();
        fetch_ready = 1'b0;
        #1;
        chk("wrap_addr0", 32'(cnt),         32'h00);
        chk("wrap_flag2", 32'(wrap_err),    32'd0);
        chk("wrap_fv",    32'(fetch_valid), 32'd1);
`endif
        // Asynchronous reset in the middle of HALT
        halt_req = 1'b1;
        tick();
        #1;
        chk("pre_rst_halted", 32'(halted), 32'd1);
        rst = 1'b0;
        #1;
        chk("async_halted", 32'(halted),      32'd0);
        chk("async_fv",     32'(fetch_valid), 32'd0);
        chk("async_load",   32'(cnt_load),    32'd0);
        chk("async_wrap",   32'(wrap_err),    32'd0);
        halt_req = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("restart_load", 32'(cnt_load), 32'd1);
        chk("restart_in",   32'(cnt_in),   32'h05);
        fetch_ready = 1'b1; exp_q.push_back(5'h05);
        tick();
        #1;
        chk("restart_fv", 32'(fetch_valid), 32'd1);
        tick();
        fetch_ready = 1'b0;
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
